gpio_irq_capture: RTL and testbench
===================================

// Module: gpio_irq_capture
// PURPOSE
//  Multi-channel GPIO input conditioner and interrupt capture. It generalises the single GPIO/GPIO2 pair to
//  C_NUM_CH channels of C_GPIO_WIDTH bits each, stage by stage:
//  - per-bit synchroniser, then debounce filter
//  - per-bit edge/mode detection into sticky W1C status bits
//  - one aggregated level interrupt, ip2intc_irpt
//  Sits between the pad-side gpio inputs and the AXI register block, which drives the enable/mode/clear controls.
// PARAMETERS
//  C_NUM_CH        2   number of channels (>=1)
//  C_GPIO_WIDTH    32  bits per channel (1..32)
//  C_SYNC_STAGES   2   synchroniser flops per bit (>=2)
//  C_DEBOUNCE_CYC  4   consecutive stable cycles to accept a change (>=1; 1 = no filtering)
//  N = C_NUM_CH*C_GPIO_WIDTH; channel c occupies bits [c*C_GPIO_WIDTH +: C_GPIO_WIDTH]
// PORTS
//  clk            in   1    system clock
//  rst            in   1    asynchronous reset, active-high
//  gpio_io_i      in   N    raw asynchronous pad inputs, all channels
//  gpio_data_o    out  N    debounced, synchronised input value (readback)
//  irq_mode       in   2*N  per-bit mode at [2*b+:2]: 00 off, 01 rising, 10 falling, 11 both edges
//  irq_en         in   N    per-bit interrupt enable (IER)
//  gier           in   1    global interrupt enable
//  isr_clr        in   N    one-cycle W1C clear strobe per ISR bit
//  isr_o          out  N    sticky interrupt status (ISR)
//  ch_irq_o       out  C_NUM_CH  per-channel OR of isr_o
//  ip2intc_irpt   out  1    gier & |isr, registered
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all sync flops, stable, stable_q, counters, isr_o, ch_irq_o and ip2intc_irpt clear to 0
//   - gpio_data_o = 0
//   - a pad held high through reset yields one rising event once filtered; this is intentional
//  Sync: S = C_SYNC_STAGES flop chain per bit; sync_q = last stage.
//  Debounce, per bit, with counter width $clog2(C_DEBOUNCE_CYC+1):
//   - sync_q == stable: cnt <= 0
//   - sync_q != stable and cnt < D-1: cnt <= cnt+1
//   - sync_q != stable and cnt == D-1: stable <= sync_q, cnt <= 0
//   - any return to equality before acceptance restarts the count, so glitches shorter than D cycles are dropped
//   - gpio_data_o = stable
//  Latency: pad change set up before edge k appears on gpio_data_o after edge k+S+D-1.
//  Edge detect:
//   - stable_q <= stable each cycle
//   - rise = stable & ~stable_q; fall = ~stable & stable_q
//   - evt[b] selected by irq_mode[b]; mode 00 never fires
//  ISR, per bit, each edge:
//   - isr <= (isr & ~isr_clr) | (evt & irq_en)
//   - set wins over a simultaneous clear; events are never lost
//   - isr sets one cycle after gpio_data_o changes (edge k+S+D)
//   - isr bits with irq_en=0 never set; existing set bits stay set when irq_en drops
//   - changing irq_mode mid-operation takes effect on the next cycle; no retroactive events
//  ch_irq_o[c] = |isr[channel c], combinational from isr.
//  ip2intc_irpt <= gier & |isr, i.e. one cycle after isr (edge k+S+D+1).
//   - deasserts one cycle after the last isr bit clears or gier drops
//  Reset mid-filter discards counters and pending edges; no event is generated from pre-reset activity.
//  Synthesisable; no latches; all state on clk.
// TESTING (C_NUM_CH=2, C_GPIO_WIDTH=8, S=2, D=4)
//  1 Reset, rst=1: all outputs 0; release with gpio_io_i=0 -> outputs stay 0 for 20 cycles.
//  2 ch0 bit0 mode=01, en=1, gier=1; pad rises before edge 10 -> gpio_data_o[0] at 15, isr_o[0] at 16,
//    ch_irq_o[0] at 16, ip2intc_irpt at 17.
//  3 Glitch: pad high 3 cycles then low -> gpio_data_o, isr_o, ip2intc_irpt unchanged; a 4-cycle pulse is accepted.
//  4 ch1 bit7 (b=15) mode=10: rise then fall -> no set on rise; isr_o[15] set on fall only.
//    Mode=11 -> set on both edges.
//  5 Clear collision: isr_clr[0] pulsed on the same edge a new bit0 event sets -> isr_o[0] stays 1.
//    A lone clear -> 0, then ip2intc_irpt 0 one cycle later.
//  6 gier=0 with isr_o=8'h01 -> ip2intc_irpt 0 while isr_o holds; gier=1 -> irpt 1 next cycle.
//    Assert rst mid-count -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/gpio_irq_capture.sv
// Multi-channel GPIO input conditioner: per-bit synchroniser and debounce filter,
// edge/mode detection into sticky W1C status bits, and an aggregated level interrupt.
module gpio_irq_capture #(
  parameter int C_NUM_CH       = 2,
  parameter int C_GPIO_WIDTH   = 32,
  parameter int C_SYNC_STAGES  = 2,
  parameter int C_DEBOUNCE_CYC = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [C_NUM_CH*C_GPIO_WIDTH-1:0]   gpio_io_i,
  output logic [C_NUM_CH*C_GPIO_WIDTH-1:0]   gpio_data_o,
  input  logic [2*C_NUM_CH*C_GPIO_WIDTH-1:0] irq_mode,
  input  logic [C_NUM_CH*C_GPIO_WIDTH-1:0]   irq_en,
  input  logic                             gier,
  input  logic [C_NUM_CH*C_GPIO_WIDTH-1:0]   isr_clr,
  output logic [C_NUM_CH*C_GPIO_WIDTH-1:0]   isr_o,
  output logic [C_NUM_CH-1:0]                ch_irq_o,
  output logic                             ip2intc_irpt
);

  localparam int unsigned N   = C_NUM_CH * C_GPIO_WIDTH;
  localparam int unsigned NCH = C_NUM_CH;
  localparam int unsigned W   = C_GPIO_WIDTH;
  localparam int unsigned S   = C_SYNC_STAGES;
  localparam int unsigned CW  = $clog2(C_DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_DEBOUNCE_CYC - 1);

  logic [N-1:0]  sync_r [S];
  logic [N-1:0]  sync_q;
  logic [CW-1:0] cnt [N];
  logic [N-1:0]  stable;
  logic [N-1:0]  stable_q;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [N-1:0]  evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < S; s++) sync_r[s] <= '0;
    end else begin
      sync_r[0] <= gpio_io_i;
      for (int unsigned s = 1; s < S; s++) sync_r[s] <= sync_r[s-1];
    end
  end

  assign sync_q = sync_r[S-1];

  // Any sample equal to the accepted value restarts the count, dropping short glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int unsigned b = 0; b < N; b++) cnt[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < N; b++) begin
        if (sync_q[b] == stable[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          stable[b] <= sync_q[b];
          cnt[b]    <= '0;
        end else begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

  assign gpio_data_o = stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable_q <= '0;
    else     stable_q <= stable;
  end

  always_comb begin
    rise = stable & ~stable_q;
    fall = ~stable & stable_q;
    evt  = '0;
    for (int unsigned b = 0; b < N; b++) begin
      evt[b] = (irq_mode[2*b] & rise[b]) | (irq_mode[2*b+1] & fall[b]);
    end
  end

  // New events are ORed in after the clear so a colliding clear never loses an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isr_o        <= '0;
      ip2intc_irpt <= 1'b0;
    end else begin
      isr_o        <= (isr_o & ~isr_clr) | (evt & irq_en);
      ip2intc_irpt <= gier & (|isr_o);
    end
  end

  always_comb begin
    ch_irq_o = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      ch_irq_o[c] = |isr_o[c*W +: W];
    end
  end

endmodule

// File: tb/tb_gpio_irq_capture.sv
// Self-checking bench for gpio_irq_capture: directed vector table, hand-written
// corner sequences and randomized stimulus against a window-based reference model.
module tb_gpio_irq_capture;

  localparam int NCH = 2;
  localparam int W   = 8;
  localparam int S   = 2;
  localparam int D   = 4;
  localparam int N   = NCH * W;

  logic           clk;
  logic           rst;
  logic [N-1:0]   gpio_io_i;
  logic [N-1:0]   gpio_data_o;
  logic [2*N-1:0] irq_mode;
  logic [N-1:0]   irq_en;
  logic           gier;
  logic [N-1:0]   isr_clr;
  logic [N-1:0]   isr_o;
  logic [NCH-1:0] ch_irq_o;
  logic           ip2intc_irpt;

  int checks = 0;
  int errors = 0;

  gpio_irq_capture #(
    .C_NUM_CH      (NCH),
    .C_GPIO_WIDTH  (W),
    .C_SYNC_STAGES (S),
    .C_DEBOUNCE_CYC(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_io_i   (gpio_io_i),
    .gpio_data_o (gpio_data_o),
    .irq_mode    (irq_mode),
    .irq_en      (irq_en),
    .gier        (gier),
    .isr_clr     (isr_clr),
    .isr_o       (isr_o),
    .ch_irq_o    (ch_irq_o),
    .ip2intc_irpt(ip2intc_irpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pad history delayed S edges, and a window of the last D
  // synchronised samples; a bit is accepted when the whole window disagrees with it.
  logic [N-1:0] pad_q [$];
  logic [N-1:0] syn_hist [$];
  logic [N-1:0] m_stable, m_stable_q, m_isr;
  logic         m_irpt;

  task automatic model_reset();
    pad_q.delete();
    syn_hist.delete();
    for (int i = 0; i < S; i++) pad_q.push_back('0);
    for (int i = 0; i < D; i++) syn_hist.push_back('0);
    m_stable   = '0;
    m_stable_q = '0;
    m_isr      = '0;
    m_irpt     = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] sync_pre, nstable, evt;
    bit all_diff;
    if (rst) begin
      model_reset();
      return;
    end
    sync_pre = pad_q[S-1];
    syn_hist.push_front(sync_pre);
    void'(syn_hist.pop_back());
    nstable = m_stable;
    for (int b = 0; b < N; b++) begin
      all_diff = 1'b1;
      foreach (syn_hist[i]) if (syn_hist[i][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) nstable[b] = ~m_stable[b];
    end
    evt = '0;
    for (int b = 0; b < N; b++) begin
      if (m_stable[b] && !m_stable_q[b] && irq_mode[2*b])   evt[b] = 1'b1;
      if (!m_stable[b] && m_stable_q[b] && irq_mode[2*b+1]) evt[b] = 1'b1;
    end
    m_irpt     = gier && (m_isr != '0);
    m_isr      = (m_isr & ~isr_clr) | (evt & irq_en);
    m_stable_q = m_stable;
    m_stable   = nstable;
    pad_q.push_front(gpio_io_i);
    void'(pad_q.pop_back());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [NCH-1:0] exp_ch;
    for (int c = 0; c < NCH; c++) exp_ch[c] = (m_isr[c*W +: W] != '0);
    chk("model_data", 32'(gpio_data_o), 32'(m_stable));
    chk("model_isr", 32'(isr_o), 32'(m_isr));
    chk("model_ch_irq", 32'(ch_irq_o), 32'(exp_ch));
    chk("model_irpt", 32'(ip2intc_irpt), 32'(m_irpt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_data"}, 32'(gpio_data_o), 32'h0);
    chk({name, "_isr"}, 32'(isr_o), 32'h0);
    chk({name, "_ch"}, 32'(ch_irq_o), 32'h0);
    chk({name, "_irpt"}, 32'(ip2intc_irpt), 32'h0);
  endtask

  typedef struct {
    string        name;
    logic [N-1:0] pad;
    logic [N-1:0] clr;
    int           cyc;
    logic [N-1:0] data;
    logic [N-1:0] isr;
    logic         irpt;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [N-1:0] pad, input logic [N-1:0] clr,
                              input int cyc, input logic [N-1:0] data, input logic [N-1:0] isr,
                              input logic irpt);
    vec_t v;
    v.name = name; v.pad = pad; v.clr = clr; v.cyc = cyc;
    v.data = data; v.isr = isr; v.irpt = irpt;
    return v;
  endfunction

  vec_t vq [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] exp_ch;

    rst = 1'b1; gpio_io_i = '0; irq_mode = '0; irq_en = '0; gier = 1'b0; isr_clr = '0;
    model_reset();
    #1;
    chk_all_zero("reset");
    run(3);
    rst = 1'b0;
    run(20);
    chk_all_zero("idle");

    // bit0 rising, bit15 falling-only
    irq_mode = '0;
    irq_mode[1:0]   = 2'b01;
    irq_mode[31:30] = 2'b10;
    irq_en = 16'h8001;
    gier   = 1'b1;

    vq.push_back(mk("pre_latency", 16'h0001, 16'h0000, 5, 16'h0000, 16'h0000, 1'b0));
    vq.push_back(mk("data_lat",    16'h0001, 16'h0000, 1, 16'h0001, 16'h0000, 1'b0));
    vq.push_back(mk("isr_lat",     16'h0001, 16'h0000, 1, 16'h0001, 16'h0001, 1'b0));
    vq.push_back(mk("irq_lat",     16'h0001, 16'h0000, 1, 16'h0001, 16'h0001, 1'b1));
    vq.push_back(mk("lone_clr",    16'h0001, 16'h0001, 1, 16'h0001, 16'h0000, 1'b1));
    vq.push_back(mk("clr_irpt",    16'h0001, 16'h0000, 1, 16'h0001, 16'h0000, 1'b0));
    vq.push_back(mk("glitch3",     16'h8001, 16'h0000, 3, 16'h0001, 16'h0000, 1'b0));
    vq.push_back(mk("glitch_gone", 16'h0001, 16'h0000, 10, 16'h0001, 16'h0000, 1'b0));
    vq.push_back(mk("pulse4",      16'h8001, 16'h0000, 4, 16'h0001, 16'h0000, 1'b0));
    vq.push_back(mk("pulse4_acc",  16'h0001, 16'h0000, 2, 16'h8001, 16'h0000, 1'b0));
    vq.push_back(mk("fall_data",   16'h0001, 16'h0000, 4, 16'h0001, 16'h0000, 1'b0));
    vq.push_back(mk("fall_isr",    16'h0001, 16'h0000, 1, 16'h0001, 16'h8000, 1'b0));
    vq.push_back(mk("fall_irq",    16'h0001, 16'h0000, 1, 16'h0001, 16'h8000, 1'b1));

    foreach (vq[i]) begin
      gpio_io_i = vq[i].pad;
      isr_clr   = vq[i].clr;
      for (int n = 0; n < vq[i].cyc; n++) begin
        tick();
        isr_clr = '0;
      end
      for (int c = 0; c < NCH; c++) exp_ch[c] = (vq[i].isr[c*W +: W] != '0);
      chk({vq[i].name, "_data"}, 32'(gpio_data_o), 32'(vq[i].data));
      chk({vq[i].name, "_isr"}, 32'(isr_o), 32'(vq[i].isr));
      chk({vq[i].name, "_ch"}, 32'(ch_irq_o), 32'(exp_ch));
      chk({vq[i].name, "_irpt"}, 32'(ip2intc_irpt), 32'(vq[i].irpt));
    end

    // set-over-clear collision on bit0
    isr_clr = 16'h8000; tick(); isr_clr = '0;
    gpio_io_i = 16'h0000; run(12);
    chk("fall_no_evt_mode01", 32'(isr_o), 32'h0);
    gpio_io_i = 16'h0001; run(7);
    chk("rise_set", 32'(isr_o), 32'h0001);
    gpio_io_i = 16'h0000; run(12);
    gpio_io_i = 16'h0001; run(6);
    isr_clr = 16'h0001; tick(); isr_clr = '0;
    chk("collision_set_wins", 32'(isr_o), 32'h0001);
    isr_clr = 16'h0001; tick(); isr_clr = '0;
    chk("lone_clr2_isr", 32'(isr_o), 32'h0);
    chk("lone_clr2_irpt_hold", 32'(ip2intc_irpt), 32'h1);
    tick();
    chk("irpt_drop", 32'(ip2intc_irpt), 32'h0);

    // both-edges mode on bit15
    irq_mode[31:30] = 2'b11;
    gpio_io_i = 16'h8001; run(7);
    chk("both_rise", 32'(isr_o), 32'h8000);
    isr_clr = 16'h8000; tick(); isr_clr = '0;
    gpio_io_i = 16'h0001; run(7);
    chk("both_fall", 32'(isr_o), 32'h8000);

    // global enable gating
    isr_clr = 16'h8000; tick(); isr_clr = '0;
    irq_mode[31:30] = 2'b00;
    gpio_io_i = 16'h0000; run(12);
    gier = 1'b0;
    gpio_io_i = 16'h0001; run(9);
    chk("gier0_isr_holds", 32'(isr_o), 32'h0001);
    chk("gier0_irpt", 32'(ip2intc_irpt), 32'h0);
    gier = 1'b1; tick();
    chk("gier1_irpt", 32'(ip2intc_irpt), 32'h1);

    // async reset mid-filter, pad held high through reset
    gpio_io_i = 16'h0000; run(3);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    gpio_io_i = 16'h0001; run(2);
    rst = 1'b0;
    run(10);
    chk("rst_pad_high_evt", 32'(isr_o), 32'h0001);

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        irq_mode = $urandom;
        irq_en   = N'($urandom);
        gier     = ($urandom_range(0, 3) != 0);
      end
      gpio_io_i = gpio_io_i ^ N'($urandom & $urandom);
      isr_clr   = N'($urandom & $urandom & $urandom);
      if (i == 250) begin
        rst = 1'b1;
        model_reset();
      end
      if (i == 252) rst = 1'b0;
      tick();
    end
    isr_clr = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
